config_read_arbiter: RTL and testbench



---
 rtl/config_read_arbiter.sv | 122 ++++++++++++
 tb/tb_config_read_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_read_arbiter.sv
// Round-robin arbiter sharing one downstream config read port among NUM_REQ requesters.
// Responses return in issue order and are routed back via a requester-ID FIFO.
module config_read_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_BITS       = 8,
   parameter int DATA_BITS       = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ*ADDR_BITS-1:0]          req_addr,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   output logic [DATA_BITS-1:0]                  req_resp_data,
   output logic                                  req_resp_error,
   output logic [NUM_REQ-1:0]                    req_resp_valid,
   input  logic [NUM_REQ-1:0]                    req_resp_ready,
   output logic [ADDR_BITS-1:0]                  out_addr,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   input  logic [DATA_BITS-1:0]                  out_resp_data,
   input  logic                                  out_resp_error,
   input  logic                                  out_resp_valid,
   output logic                                  out_resp_ready,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
   output logic                                  protocol_err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant;
   logic             found;
   logic             accept;
   logic             pop;
   logic             fifo_empty;
   logic [ID_W-1:0]  head;
   logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTSTANDING-1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Search upward from the round-robin pointer, wrapping at NUM_REQ.
   always_comb begin
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   // Full check uses the pre-pop count; a freed slot is usable next cycle.
   assign accept     = (!out_valid || out_ready) && (count < CNT_W'(MAX_OUTSTANDING)) && found;
   assign fifo_empty = (count == '0);
   assign head       = id_fifo[rd_ptr];
   assign pop        = out_resp_valid && out_resp_ready;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   always_comb begin
      req_resp_valid = '0;
      out_resp_ready = 1'b0;
      if (!fifo_empty) begin
         req_resp_valid[head] = out_resp_valid;
         out_resp_ready       = req_resp_ready[head];
      end
   end

   assign req_resp_data  = out_resp_data;
   assign req_resp_error = out_resp_error;
   assign outstanding    = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_addr     <= '0;
         out_valid    <= 1'b0;
         rr_ptr       <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) id_fifo[i] <= '0;
      end else begin
         if (accept) begin
            out_addr        <= req_addr[int'(grant)*ADDR_BITS +: ADDR_BITS];
            out_valid       <= 1'b1;
            id_fifo[wr_ptr] <= grant;
            wr_ptr          <= ptr_inc(wr_ptr);
            rr_ptr          <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (pop) rd_ptr <= ptr_inc(rd_ptr);

         case ({accept, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (out_resp_valid && fifo_empty) protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_config_read_arbiter.sv
// Directed bench for config_read_arbiter: single read, RR order, full FIFO,
// in-order response stall, protocol error and asynchronous reset.
module tb_config_read_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] req_addr;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_resp_data;
   logic        req_resp_error;
   logic [3:0]  req_resp_valid;
   logic [3:0]  req_resp_ready;
   logic [7:0]  out_addr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_resp_data;
   logic        out_resp_error;
   logic        out_resp_valid;
   logic        out_resp_ready;
   logic [2:0]  outstanding;
   logic        protocol_err;

   int tests  = 0;
   int errors = 0;

   config_read_arbiter #(
      .NUM_REQ(4), .ADDR_BITS(8), .DATA_BITS(64), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
      .req_resp_data(req_resp_data), .req_resp_error(req_resp_error),
      .req_resp_valid(req_resp_valid), .req_resp_ready(req_resp_ready),
      .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
      .out_resp_data(out_resp_data), .out_resp_error(out_resp_error),
      .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
      .outstanding(outstanding), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid      = '0;
      out_ready      = 1'b0;
      out_resp_valid = 1'b0;
      req_resp_ready = '0;
      rst            = 1'b1;
      tick();
      rst            = 1'b0;
   endtask

   int n_acc;

   initial begin
      req_addr       = '0;
      req_valid      = '0;
      req_resp_ready = '0;
      out_ready      = 1'b0;
      out_resp_data  = '0;
      out_resp_error = 1'b0;
      out_resp_valid = 1'b0;
      rst            = 1'b1;
      #2;
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_out_addr", 64'(out_addr), 0);
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_protocol_err", 64'(protocol_err), 0);
      check("rst_resp_ready", 64'(out_resp_ready), 0);
      tick();
      rst = 1'b0;

      // single request from requester 2
      req_addr  = 32'h0005_0000;
      req_valid = 4'b0100;
      #1;
      check("t1_req_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      out_ready = 1'b1;
      check("t1_out_valid", 64'(out_valid), 1);
      check("t1_out_addr", 64'(out_addr), 64'h05);
      check("t1_outstanding", 64'(outstanding), 1);
      tick();
      tick();
      out_resp_valid = 1'b1;
      out_resp_data  = 64'hDEAD;
      req_resp_ready = 4'b0100;
      #1;
      check("t1_resp_valid", 64'(req_resp_valid), 64'h4);
      check("t1_resp_data", req_resp_data, 64'hDEAD);
      check("t1_out_resp_ready", 64'(out_resp_ready), 1);
      tick();
      out_resp_valid = 1'b0;
      check("t1_outstanding_end", 64'(outstanding), 0);

      // all four valid, instant responses: grants 0,1,2,3,0,...
      do_reset();
      req_addr       = 32'h4433_2211;
      req_valid      = 4'b1111;
      out_ready      = 1'b1;
      req_resp_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         out_resp_valid = (i != 0);
         #1;
         check($sformatf("t2_grant%0d", i), 64'(req_ready), 64'(1 << (i % 4)));
         if (i > 0) begin
            check($sformatf("t2_owner%0d", i), 64'(req_resp_valid), 64'(1 << ((i-1) % 4)));
            check($sformatf("t2_addr%0d", i), 64'(out_addr), 64'(8'h11 * (((i-1) % 4) + 1)));
         end
         tick();
      end
      req_valid = '0;
      tick();
      out_resp_valid = 1'b0;
      check("t2_outstanding_end", 64'(outstanding), 0);
      check("t2_no_perr", 64'(protocol_err), 0);

      // downstream never responds: exactly four accepts
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      n_acc     = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_ready != '0) n_acc++;
         tick();
      end
      check("t3_accepts", 64'(n_acc), 4);
      check("t3_outstanding_full", 64'(outstanding), 4);
      check("t3_ready_blocked", 64'(req_ready), 0);
      out_resp_valid = 1'b1;
      req_resp_ready = 4'b1111;
      #1;
      check("t3_resp_head0", 64'(req_resp_valid), 64'h1);
      check("t3_no_accept_on_pop", 64'(req_ready), 0);
      tick();
      out_resp_valid = 1'b0;
      check("t3_outstanding_pop", 64'(outstanding), 3);
      check("t3_next_accept", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      check("t3_outstanding_refill", 64'(outstanding), 4);

      // IDs 1 and 3 in flight, requester 1 stalls its response
      do_reset();
      req_valid = 4'b1010;
      out_ready = 1'b1;
      #1;
      check("t4_grant1", 64'(req_ready), 64'h2);
      tick();
      check("t4_grant3", 64'(req_ready), 64'h8);
      tick();
      req_valid      = '0;
      out_resp_valid = 1'b1;
      out_resp_data  = 64'h11;
      req_resp_ready = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("t4_stall_ready%0d", i), 64'(out_resp_ready), 0);
         check($sformatf("t4_stall_owner%0d", i), 64'(req_resp_valid), 64'h2);
         tick();
      end
      check("t4_outstanding_held", 64'(outstanding), 2);
      req_resp_ready = 4'b1010;
      #1;
      check("t4_release", 64'(out_resp_ready), 1);
      tick();
      out_resp_data = 64'h33;
      #1;
      check("t4_second_owner", 64'(req_resp_valid), 64'h8);
      tick();
      out_resp_valid = 1'b0;
      check("t4_outstanding_end", 64'(outstanding), 0);

      // unsolicited response sets sticky protocol_err
      out_resp_valid = 1'b1;
      #1;
      check("t5_resp_ready_empty", 64'(out_resp_ready), 0);
      check("t5_resp_valid_empty", 64'(req_resp_valid), 0);
      tick();
      out_resp_valid = 1'b0;
      check("t5_perr_set", 64'(protocol_err), 1);
      tick();
      tick();
      check("t5_perr_sticky", 64'(protocol_err), 1);

      // two outstanding with out_valid held, then asynchronous reset
      req_addr  = 32'h0000_9A00;
      req_valid = 4'b0010;
      out_ready = 1'b1;
      tick();
      tick();
      req_valid = '0;
      out_ready = 1'b0;
      check("t6_outstanding", 64'(outstanding), 2);
      check("t6_out_valid", 64'(out_valid), 1);
      tick();
      check("t6_addr_stable", 64'(out_addr), 64'h9A);
      check("t6_valid_stable", 64'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_arst_out_valid", 64'(out_valid), 0);
      check("t6_arst_out_addr", 64'(out_addr), 0);
      check("t6_arst_outstanding", 64'(outstanding), 0);
      check("t6_arst_perr", 64'(protocol_err), 0);
      tick();
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
